mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 16-bit pipelined core.
- Consumes the EX/MEM register outputs: MemWrite, 4-bit WB control, ALU result, store data, DstReg and flags.
- Runs the data-memory access over a req/ready handshake and stalls the upstream pipeline while memory is busy.
- Registers the result toward writeback; also handles halt latching and memory timeout.

Parameters:
- MAX_WAIT, 255: cycles waited for mem_ready before a timeout is declared (1..65535).
- ERR_DATA, 16'hFFFF: load data substituted on timeout.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- MemWrite  input  1  store request from EX/MEM.
- WB_in  input  4  WB control: [3]=RegWrite, [2]=MemtoReg, [1]=PCtoReg, [0]=Halt.
- flagsIn  input  3  ALU flags from EX/MEM.
- reg_data_in  input  16  ALU result; doubles as memory address.
- rt_in  input  16  store data.
- DstReg_in  input  4  destination register.
- mem_req  output  1  memory request.
- mem_we  output  1  1=write, 0=read.
- mem_addr  output  16  memory address.
- mem_wdata  output  16  write data.
- mem_rdata  input  16  read data; valid when mem_ready=1.
- mem_ready  input  1  access complete this cycle.
- stall  output  1  freeze PC/IF/ID/EX/MEM registers.
- WB_out  output  4  registered WB control.
- alu_data_out  output  16  registered ALU result.
- mem_data_out  output  16  registered load data.
- DstReg_out  output  4  registered destination register.
- flagsOut  output  3  registered flags.
- halted  output  1  sticky; a Halt reached MEM/WB.
- mem_err  output  1  sticky; a timeout occurred.
- stall_cnt  output  16  saturating count of stall cycles.

Behaviour:
- Reset: state IDLE. All registered outputs 0: WB_out, alu_data_out, mem_data_out, DstReg_out, flagsOut, halted, mem_err, stall_cnt.
- access = (MemWrite | WB_in[2]) & ~halted.
- IDLE:
  - mem_req = access & ~rst, combinational.
  - mem_we = MemWrite; mem_addr = reg_data_in; mem_wdata = rt_in.
  - If access and mem_ready in the same cycle: zero-stall hit; MEM/WB loads inputs next edge, with mem_data_out = mem_rdata.
  - If access and not mem_ready: latch we/addr/wdata/WB/dst/flags/ALU into a holding register; go to WAIT; stall = 1 in that same cycle (combinational); wait counter = 1.
  - If no access: MEM/WB loads inputs; mem_data_out holds its old value.
- WAIT:
  - mem_req = 1; address and data come from the holding register and stay stable.
  - stall = 1; MEM/WB loads a bubble (WB_out = 0, other fields hold).
  - stall_cnt increments each stall cycle and saturates at 16'hFFFF.
  - On mem_ready: MEM/WB loads the held fields plus mem_rdata (reads only); go to IDLE; stall = 0 that cycle.
  - Timeout: wait counter reaches MAX_WAIT without ready:
    - mem_err set.
    - MEM/WB loads the held fields with mem_data_out = ERR_DATA and WB_out[0] forced to 1 (Halt).
    - mem_req drops; go to IDLE.
- Store completion writes no data to mem_data_out; WB fields pass through unchanged.
- Halt: when WB_out[0] becomes 1, halted sets on that edge.
  - Thereafter no new memory requests; MEM/WB loads bubbles.
  - Clears only on rst.
- MemWrite with WB_in[2] set simultaneously is illegal upstream; the block treats it as a write.
- rst in WAIT: next edge returns to IDLE; mem_req forced 0 during the reset cycle. The memory side must discard the pending access.
- Latency: one cycle through MEM/WB on a hit; 1 + N cycles when ready arrives N cycles after the request.

Decomposition:
- Shared package cpu_pkg:
  - WB bit index constants (WB_REGWRITE=3, WB_MEMTOREG=2, WB_PCTOREG=1, WB_HALT=0).
  - State enum {IDLE, WAIT}.
  - WB control type.
- Sub-module mem_wb_reg: the MEM/WB register with load and bubble inputs, built from the team's existing register primitives.
- The FSM, holding register and counters live in mem_wb_stage.

Test Plan:
- Load hit: WB_in=4'b1100, reg_data_in=16'h0040, mem_ready=1 with mem_rdata=16'hBEEF in the same cycle -> stall never 1; next edge mem_data_out=16'hBEEF, WB_out=4'b1100.
- Load miss: same load with ready 3 cycles later -> stall high exactly 3 cycles; mem_addr stays 16'h0040; WB_out=0 for 3 cycles, then 4'b1100 with data; stall_cnt=3.
- Store miss: MemWrite=1, reg_data_in=16'h0010, rt_in=16'h1234, ready after 2 cycles -> mem_we=1, mem_wdata=16'h1234 held stable; mem_data_out unchanged.
- Timeout with MAX_WAIT=4 and ready never asserted -> after 4 WAIT cycles mem_err=1, mem_data_out=16'hFFFF, WB_out[0]=1; halted=1 one edge later; mem_req stays 0 afterwards.
- Halt passthrough: WB_in=4'b0001, then a load -> halted=1; the load produces no mem_req and WB_out=0.
- Reset in WAIT: rst asserted on the 2nd wait cycle -> next edge state IDLE, stall=0, all outputs 0; mem_req=0 during the rst cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Covers WB control bit positions, the memory-stage states and the small types they use.
package cpu_pkg;

  localparam int WB_REGWRITE = 3;
  localparam int WB_MEMTOREG = 2;
  localparam int WB_PCTOREG  = 1;
  localparam int WB_HALT     = 0;

  typedef logic [3:0] wb_ctrl_t;

  typedef enum logic {IDLE, WAIT} mem_state_e;

  // Snapshot of a stalled MEM-stage instruction; the address doubles as the ALU result.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    wb_ctrl_t    wb;
    logic [3:0]  dst;
    logic [2:0]  flags;
  } hold_t;

  // A store or a load needs the data memory; a simultaneous store+load is treated as a store.
  function automatic logic is_access(input logic mem_write, input wb_ctrl_t wb);
    return mem_write | wb[WB_MEMTOREG];
  endfunction

  function automatic logic wb_writes_reg(input wb_ctrl_t wb);
    return wb[WB_REGWRITE] | wb[WB_PCTOREG];
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a load enable and a bubble input.
// A bubble clears only the WB control so the other fields keep their last values.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        mem_load,
  input  wb_ctrl_t    wb_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] mem_in,
  input  logic [3:0]  dst_in,
  input  logic [2:0]  flags_in,
  output wb_ctrl_t    wb_out,
  output logic [15:0] alu_out,
  output logic [15:0] mem_out,
  output logic [3:0]  dst_out,
  output logic [2:0]  flags_out
);

  wb_ctrl_t    wb_q, wb_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] mem_q, mem_d;
  logic [3:0]  dst_q, dst_d;
  logic [2:0]  flags_q, flags_d;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path infers a latch.
    wb_d    = wb_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    dst_d   = dst_q;
    flags_d = flags_q;
    if (bubble) begin
      wb_d = '0;
    end else if (load) begin
      wb_d    = wb_in;
      alu_d   = alu_in;
      dst_d   = dst_in;
      flags_d = flags_in;
      if (mem_load) mem_d = mem_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wb_q    <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      dst_q   <= '0;
      flags_q <= '0;
    end else begin
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      dst_q   <= dst_d;
      flags_q <= flags_d;
    end
  end

  assign wb_out    = wb_q;
  assign alu_out   = alu_q;
  assign mem_out   = mem_q;
  assign dst_out   = dst_q;
  assign flags_out = flags_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage of the 16-bit core: data-memory req/ready handshake, pipeline stall,
// timeout recovery, sticky halt, and the MEM/WB register toward writeback.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int          MAX_WAIT = 255,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [3:0]  WB_in,
  input  logic [2:0]  flagsIn,
  input  logic [15:0] reg_data_in,
  input  logic [15:0] rt_in,
  input  logic [3:0]  DstReg_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [3:0]  WB_out,
  output logic [15:0] alu_data_out,
  output logic [15:0] mem_data_out,
  output logic [3:0]  DstReg_out,
  output logic [2:0]  flagsOut,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  mem_state_e  state_q, state_d;
  hold_t       hold_q, hold_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        halted_q, halted_d;
  logic        mem_err_q, mem_err_d;

  logic        block, access;
  logic        reg_load, reg_bubble, reg_mem_load;
  wb_ctrl_t    reg_wb;
  logic [15:0] reg_alu, reg_mem;
  logic [3:0]  reg_dst;
  logic [2:0]  reg_flags;

  always_comb begin
    // A halt already sitting in MEM/WB blocks the instruction behind it, a cycle before halted shows it.
    block  = halted_q | WB_out[WB_HALT];
    access = is_access(MemWrite, WB_in) & ~block;

    state_d      = state_q;
    hold_d       = hold_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    halted_d     = halted_q | WB_out[WB_HALT];
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = MemWrite;
    mem_addr     = reg_data_in;
    mem_wdata    = rt_in;
    reg_load     = 1'b0;
    reg_bubble   = 1'b0;
    reg_mem_load = 1'b0;
    reg_wb       = WB_in;
    reg_alu      = reg_data_in;
    reg_mem      = mem_rdata;
    reg_dst      = DstReg_in;
    reg_flags    = flagsIn;

    unique case (state_q)
      IDLE: begin
        if (block) begin
          reg_bubble = 1'b1;
        end else if (access) begin
          mem_req = ~rst;
          if (mem_ready) begin
            reg_load     = 1'b1;
            reg_mem_load = ~MemWrite;
          end else begin
            stall      = 1'b1;
            reg_bubble = 1'b1;
            hold_d     = '{we: MemWrite, addr: reg_data_in, wdata: rt_in,
                           wb: WB_in, dst: DstReg_in, flags: flagsIn};
            wait_cnt_d = 16'd1;
            state_d    = WAIT;
          end
        end else begin
          reg_load = 1'b1;
        end
      end
      WAIT: begin
        mem_req   = ~rst;
        mem_we    = hold_q.we;
        mem_addr  = hold_q.addr;
        mem_wdata = hold_q.wdata;
        reg_wb    = hold_q.wb;
        reg_alu   = hold_q.addr;
        reg_dst   = hold_q.dst;
        reg_flags = hold_q.flags;
        if (mem_ready) begin
          reg_load     = 1'b1;
          reg_mem_load = ~hold_q.we;
          state_d      = IDLE;
        end else if (wait_cnt_q == 16'(MAX_WAIT)) begin
          // Give up: deliver the instruction with error data and force a halt behind it.
          stall           = 1'b1;
          reg_load        = 1'b1;
          reg_mem_load    = 1'b1;
          reg_mem         = ERR_DATA;
          reg_wb[WB_HALT] = 1'b1;
          mem_err_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          stall      = 1'b1;
          reg_bubble = 1'b1;
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
      mem_err_q   <= mem_err_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (reg_load),
    .bubble    (reg_bubble),
    .mem_load  (reg_mem_load),
    .wb_in     (reg_wb),
    .alu_in    (reg_alu),
    .mem_in    (reg_mem),
    .dst_in    (reg_dst),
    .flags_in  (reg_flags),
    .wb_out    (WB_out),
    .alu_out   (alu_data_out),
    .mem_out   (mem_data_out),
    .dst_out   (DstReg_out),
    .flags_out (flagsOut)
  );

  assign halted    = halted_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a scoreboard queue of expected MEM/WB contents
// is filled as each access completes and drained when the register updates.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [3:0]  WB_in;
  logic [2:0]  flagsIn;
  logic [15:0] reg_data_in;
  logic [15:0] rt_in;
  logic [3:0]  DstReg_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic [3:0]  WB_out;
  logic [15:0] alu_data_out;
  logic [15:0] mem_data_out;
  logic [3:0]  DstReg_out;
  logic [2:0]  flagsOut;
  logic        halted;
  logic        mem_err;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [3:0]  wb;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [3:0]  dst;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_mem = '0;
  logic [15:0] exp_stall = '0;

  always #5 clk = ~clk;

  mem_wb_stage #(.MAX_WAIT(4), .ERR_DATA(16'hFFFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemWrite     (MemWrite),
    .WB_in        (WB_in),
    .flagsIn      (flagsIn),
    .reg_data_in  (reg_data_in),
    .rt_in        (rt_in),
    .DstReg_in    (DstReg_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .WB_out       (WB_out),
    .alu_data_out (alu_data_out),
    .mem_data_out (mem_data_out),
    .DstReg_out   (DstReg_out),
    .flagsOut     (flagsOut),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wb, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [3:0] dst, input logic [2:0] fl);
    MemWrite    = we;
    WB_in       = wb;
    reg_data_in = addr;
    rt_in       = wdata;
    DstReg_in   = dst;
    flagsIn     = fl;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_wb"},    WB_out,       e.wb);
      check({tag, "_alu"},   alu_data_out, e.alu);
      check({tag, "_mem"},   mem_data_out, e.mem);
      check({tag, "_dst"},   DstReg_out,   e.dst);
      check({tag, "_flags"}, flagsOut,     e.flags);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},        WB_out,       0);
    check({tag, "_alu"},       alu_data_out, 0);
    check({tag, "_mem"},       mem_data_out, 0);
    check({tag, "_dst"},       DstReg_out,   0);
    check({tag, "_flags"},     flagsOut,     0);
    check({tag, "_halted"},    halted,       0);
    check({tag, "_mem_err"},   mem_err,      0);
    check({tag, "_stall_cnt"}, stall_cnt,    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'h0, 3'b000);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    exp_mem   = '0;
    exp_stall = '0;
  endtask

  // One memory access whose ready arrives n_wait cycles after the request.
  // During the wait the upstream inputs are scrambled to prove the holding register is used.
  task automatic run_access(input logic we, input logic [3:0] wb, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [3:0] dst, input logic [2:0] fl,
                            input logic [15:0] rdata, input int n_wait, input string tag);
    for (int k = 0; k <= n_wait; k++) begin
      @(negedge clk);
      if (k == 0) begin
        drive(we, wb, addr, wdata, dst, fl);
      end else begin
        reg_data_in = 16'($urandom);
        rt_in       = 16'($urandom);
      end
      mem_ready = (k == n_wait);
      mem_rdata = (k == n_wait) ? rdata : ~rdata;
      #1;
      check({tag, "_req"},   mem_req,  1);
      check({tag, "_addr"},  mem_addr, addr);
      check({tag, "_we"},    mem_we,   we);
      if (we) check({tag, "_wdata"}, mem_wdata, wdata);
      check({tag, "_stall"}, stall,    (k < n_wait));
      if (k == n_wait) begin
        if (!we && wb[2]) exp_mem = rdata;
        sb.push_back('{wb: wb, alu: addr, mem: exp_mem, dst: dst, flags: fl});
      end
      @(posedge clk); #1;
      if (k < n_wait) check({tag, "_bubble"}, WB_out, 0);
      else            compare_out(tag);
    end
    exp_stall += 16'(n_wait);
    check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
  endtask

  // Non-memory instruction: passes straight through, load data untouched.
  task automatic run_passthru(input logic [3:0] wb, input logic [15:0] addr,
                              input logic [3:0] dst, input logic [2:0] fl, input string tag);
    @(negedge clk);
    drive(1'b0, wb, addr, 16'h0, dst, fl);
    mem_ready = 1'b0;
    #1;
    check({tag, "_req"},   mem_req, 0);
    check({tag, "_stall"}, stall,   0);
    sb.push_back('{wb: wb, alu: addr, mem: exp_mem, dst: dst, flags: fl});
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'h0, 3'b000);
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    run_access(1'b0, 4'b1100, 16'h0040, 16'h0000, 4'd5, 3'b010, 16'hBEEF, 0, "load_hit");
    run_passthru(4'b1000, 16'h0077, 4'd3, 3'b101, "alu_op");
    run_access(1'b0, 4'b1100, 16'h0040, 16'h0000, 4'd6, 3'b001, 16'hCAFE, 3, "load_miss");
    run_access(1'b1, 4'b0000, 16'h0010, 16'h1234, 4'd0, 3'b100, 16'h5555, 2, "store_miss");
    run_access(1'b1, 4'b0000, 16'h0020, 16'hA5A5, 4'd1, 3'b000, 16'h7777, 0, "store_hit");

    // Timeout: ready never comes; IDLE miss cycle plus four WAIT cycles.
    @(negedge clk);
    drive(1'b0, 4'b1100, 16'h0200, 16'h0, 4'd7, 3'b011);
    mem_ready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("tmo_req",   mem_req,  1);
      check("tmo_addr",  mem_addr, 16'h0200);
      check("tmo_stall", stall,    1);
      if (k == 4) begin
        exp_mem = 16'hFFFF;
        sb.push_back('{wb: 4'b1101, alu: 16'h0200, mem: 16'hFFFF, dst: 4'd7, flags: 3'b011});
      end
      @(posedge clk); #1;
      if (k < 4) begin
        check("tmo_bubble", WB_out,  0);
        check("tmo_noerr",  mem_err, 0);
      end else begin
        compare_out("tmo");
        check("tmo_err",       mem_err, 1);
        check("tmo_halt_late", halted,  0);
      end
    end
    exp_stall += 16'd5;
    check("tmo_stall_cnt", stall_cnt, exp_stall);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_tmo_req",   mem_req, 0);
      check("post_tmo_stall", stall,   0);
      @(posedge clk); #1;
      check("post_tmo_halted", halted, 1);
      check("post_tmo_wb",     WB_out, 0);
    end
    do_reset();

    // Halt passthrough, then a load that must be suppressed.
    run_passthru(4'b0001, 16'h0ABC, 4'd2, 3'b001, "halt_pass");
    @(negedge clk);
    drive(1'b0, 4'b1100, 16'h0040, 16'h0, 4'd9, 3'b110);
    mem_ready = 1'b1;
    mem_rdata = 16'h4321;
    #1;
    check("halt_load_req",   mem_req, 0);
    check("halt_load_stall", stall,   0);
    @(posedge clk); #1;
    check("halt_load_wb",     WB_out,       0);
    check("halt_load_halted", halted,       1);
    check("halt_load_alu",    alu_data_out, 16'h0ABC);
    check("halt_load_mem",    mem_data_out, 16'h0000);
    do_reset();

    // Reset on the second wait cycle.
    @(negedge clk);
    drive(1'b0, 4'b1100, 16'h0300, 16'h0, 4'd4, 3'b111);
    mem_ready = 1'b0;
    #1;
    check("rstw_stall0", stall, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rstw_req1",   mem_req, 1);
    check("rstw_stall1", stall,   1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'h0, 3'b000);
    #1;
    check("rstw_req_in_rst", mem_req, 0);
    @(posedge clk); #1;
    check("rstw_stall_after", stall, 0);
    check_all_zero("rstw");
    @(negedge clk);
    rst = 1'b0;
    exp_mem   = '0;
    exp_stall = '0;

    run_access(1'b0, 4'b1100, 16'h0042, 16'h0000, 4'd8, 3'b011, 16'h1357, 1, "recover");

    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
